// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - D-stage data/HILO hazard scoreboard with forwarding selects
// Optional perf counters enabled by HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int REG_AW  = 5,
    parameter int TW      = 2,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4,
    localparam int SW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs,
    input  logic [REG_AW-1:0] d_rt,
    input  logic [TW-1:0]     d_tuse_rs,
    input  logic [TW-1:0]     d_tuse_rt,
    input  logic [REG_AW-1:0] d_dst,
    input  logic [TW-1:0]     d_tnew,
    input  logic              d_md_start,
    input  logic              d_md_div,
    input  logic              d_uses_hilo,
    input  logic              flush,
    output logic              stall,
    output logic [SW-1:0]     fwd_sel_rs,
    output logic [SW-1:0]     fwd_sel_rt,
    output logic              md_busy,
    output logic [31:0]       perf_data_stall,
    output logic [31:0]       perf_hilo_stall
);

    localparam logic [TW-1:0] TUSE_NONE = '1;

    logic [DEPTH-1:0]  slot_valid;
    logic [REG_AW-1:0] slot_dst  [DEPTH];
    logic [TW-1:0]     slot_tnew [DEPTH];
    logic [CNT_W-1:0]  md_cnt;

    logic              hit_rs, hit_rt;
    logic [SW-1:0]     k_rs, k_rt;
    logic [TW-1:0]     tn_rs, tn_rt;
    logic              dstall_rs, dstall_rt;
    logic              data_stall, hilo_stall, issue;

    // Scan oldest to youngest so the youngest matching slot overwrites older ones.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        k_rs   = '0;
        k_rt   = '0;
        tn_rs  = '0;
        tn_rt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_valid[i] && d_rs != '0 && slot_dst[i] == d_rs) begin
                hit_rs = 1'b1;
                k_rs   = SW'(i + 1);
                tn_rs  = slot_tnew[i];
            end
            if (slot_valid[i] && d_rt != '0 && slot_dst[i] == d_rt) begin
                hit_rt = 1'b1;
                k_rt   = SW'(i + 1);
                tn_rt  = slot_tnew[i];
            end
        end
    end

    assign dstall_rs  = hit_rs && (d_tuse_rs != TUSE_NONE) && (tn_rs > d_tuse_rs);
    assign dstall_rt  = hit_rt && (d_tuse_rt != TUSE_NONE) && (tn_rt > d_tuse_rt);
    assign md_busy    = (md_cnt != '0);
    assign data_stall = ~flush & d_valid & (dstall_rs | dstall_rt);
    assign hilo_stall = ~flush & d_valid & d_uses_hilo & md_busy;
    assign stall      = data_stall | hilo_stall;
    assign issue      = d_valid & ~stall & ~flush;
    assign fwd_sel_rs = (hit_rs && !dstall_rs) ? k_rs : '0;
    assign fwd_sel_rt = (hit_rt && !dstall_rt) ? k_rt : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_dst[i]  <= '0;
                slot_tnew[i] <= '0;
            end
        end else begin
            slot_valid[0] <= issue && (d_dst != '0);
            slot_dst[0]   <= d_dst;
            slot_tnew[0]  <= d_tnew;
            for (int i = 1; i < DEPTH; i++) begin
                slot_valid[i] <= slot_valid[i-1] & ~flush;
                slot_dst[i]   <= slot_dst[i-1];
                slot_tnew[i]  <= (slot_tnew[i-1] != '0) ? slot_tnew[i-1] - TW'(1) : '0;
            end
        end
    end

    // A flushed md start never issues, so it cannot reload an in-progress count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt <= '0;
        end else if (issue && d_md_start) begin
            md_cnt <= d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_W'(1);
        end
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_data_stall <= '0;
            perf_hilo_stall <= '0;
        end else begin
            if (data_stall && perf_data_stall != '1)
                perf_data_stall <= perf_data_stall + 32'd1;
            if (hilo_stall && !data_stall && perf_hilo_stall != '1)
                perf_hilo_stall <= perf_hilo_stall + 32'd1;
        end
    end
`else
    assign perf_data_stall = 32'd0;
    assign perf_hilo_stall = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized and directed check of hazard_scoreboard against a queue model
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        d_valid;
    logic [4:0]  d_rs, d_rt, d_dst;
    logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
    logic        d_md_start, d_md_div, d_uses_hilo, flush;
    logic        stall, md_busy;
    logic [1:0]  fwd_sel_rs, fwd_sel_rt;
    logic [31:0] perf_data_stall, perf_hilo_stall;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_dst(d_dst), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_uses_hilo(d_uses_hilo),
        .flush(flush), .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
        .md_busy(md_busy), .perf_data_stall(perf_data_stall), .perf_hilo_stall(perf_hilo_stall)
    );

    int checks = 0;
    int errors = 0;

    // In-flight instructions, youngest first, stamped with the edge they entered E.
    int q_dst[$], q_tnew[$], q_edge[$];
    int edge_cnt, busy_end;
    int unsigned perf_d, perf_h;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q_dst.delete(); q_tnew.delete(); q_edge.delete();
        edge_cnt = 0; busy_end = 0; perf_d = 0; perf_h = 0;
    endtask

    task automatic lookup(input int s, input int tuse, output bit st, output int fw);
        st = 0;
        fw = 0;
        if (s == 0) return;
        for (int i = 0; i < q_dst.size(); i++) begin
            if (q_dst[i] == s) begin
                int k, t;
                k = edge_cnt - q_edge[i];
                t = q_tnew[i] - k;
                if (t < 0) t = 0;
                st = (tuse != 3) && (t > tuse);
                fw = st ? 0 : k + 1;
                return;
            end
        end
    endtask

    task automatic check_perf();
`ifdef HAZARD_SCOREBOARD_PERF_EN
        check("perf_data", perf_data_stall, perf_d);
        check("perf_hilo", perf_hilo_stall, perf_h);
`else
        check("perf_data", perf_data_stall, 32'd0);
        check("perf_hilo", perf_hilo_stall, 32'd0);
`endif
    endtask

    // Drive one D-stage cycle at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle(input int v, input int rs, input int tur, input int rt, input int tut,
                         input int dst, input int tn, input int mds, input int mdd,
                         input int uh, input int fl);
        bit srs, srt, busy, hst, exp_stall, iss;
        int frs, frt;
        d_valid = v[0]; d_rs = rs[4:0]; d_tuse_rs = tur[1:0]; d_rt = rt[4:0]; d_tuse_rt = tut[1:0];
        d_dst = dst[4:0]; d_tnew = tn[1:0]; d_md_start = mds[0]; d_md_div = mdd[0];
        d_uses_hilo = uh[0]; flush = fl[0];
        #1;
        lookup(rs, tur, srs, frs);
        lookup(rt, tut, srt, frt);
        busy      = edge_cnt < busy_end;
        hst       = v[0] && uh[0] && busy;
        exp_stall = !fl[0] && v[0] && (srs || srt || hst);
        iss       = v[0] && !exp_stall && !fl[0];
        check("stall", {31'd0, stall}, {31'd0, exp_stall});
        check("fwd_rs", {30'd0, fwd_sel_rs}, frs);
        check("fwd_rt", {30'd0, fwd_sel_rt}, frt);
        check("md_busy", {31'd0, md_busy}, {31'd0, busy});
        check_perf();
        @(posedge clk);
        edge_cnt++;
        if (fl[0]) begin
            q_dst.delete(); q_tnew.delete(); q_edge.delete();
        end
        if (iss && dst != 0) begin
            q_dst.push_front(dst); q_tnew.push_front(tn); q_edge.push_front(edge_cnt);
        end
        while (q_edge.size() > 0 && edge_cnt - q_edge[q_edge.size()-1] >= 3) begin
            void'(q_dst.pop_back()); void'(q_tnew.pop_back()); void'(q_edge.pop_back());
        end
        if (iss && mds[0]) busy_end = edge_cnt + (mdd[0] ? 10 : 5);
        if (!fl[0] && v[0] && (srs || srt)) perf_d++;
        else if (!fl[0] && hst) perf_h++;
        @(negedge clk);
    endtask

    task automatic bubble();
        cycle(0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        d_valid = 1'b1; d_uses_hilo = 1'b1; d_rs = 5'd0; d_rt = 5'd0; flush = 1'b0;
        d_md_start = 1'b0; d_tuse_rs = 2'd0; d_tuse_rt = 2'd0;
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_fwd_rs", {30'd0, fwd_sel_rs}, 32'd0);
        check_perf();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        d_valid = 0; d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_dst = 0; d_tnew = 0;
        d_md_start = 0; d_md_div = 0; d_uses_hilo = 0; flush = 0;
        model_clear();
        @(negedge clk); @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_md_busy", {31'd0, md_busy}, 32'd0);
        check("reset_fwd_rt", {30'd0, fwd_sel_rt}, 32'd0);
        check_perf();
        reset_n = 1'b1;
        @(negedge clk);

        // lw $t0 then dependent addu: one stall, then forward from M
        cycle(1, 1, 1, 2, 1, 8, 2, 0, 0, 0, 0);
        cycle(1, 8, 1, 0, 3, 10, 1, 0, 0, 0, 0);
        check("t1_stalled_once", {31'd0, stall}, 32'd0);
        cycle(1, 8, 1, 0, 3, 10, 1, 0, 0, 0, 0);
        bubble(); bubble(); bubble();
        // addu then beq tuse=0 (stall) and tuse=1 (no stall)
        cycle(1, 0, 3, 0, 3, 9, 1, 0, 0, 0, 0);
        cycle(1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        cycle(1, 9, 0, 0, 3, 0, 0, 0, 0, 0, 0);
        bubble(); bubble(); bubble();
        cycle(1, 0, 3, 0, 3, 9, 1, 0, 0, 0, 0);
        cycle(1, 9, 1, 0, 3, 0, 0, 0, 0, 0, 0);
        bubble(); bubble(); bubble();
        // two writers of $5: youngest wins
        cycle(1, 0, 3, 0, 3, 5, 1, 0, 0, 0, 0);
        cycle(1, 0, 3, 0, 3, 5, 1, 0, 0, 0, 0);
        cycle(1, 0, 3, 5, 2, 0, 0, 0, 0, 0, 0);
        bubble(); bubble(); bubble();
        // div then mflo held in D; mult then mflo
        cycle(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0);
        for (int i = 0; i < 11; i++) cycle(1, 0, 3, 0, 3, 2, 0, 0, 0, 1, 0);
        cycle(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0, 3, 0, 3, 2, 0, 0, 0, 1, 0);
        bubble(); bubble(); bubble();
        // flush kills lw in slot0 and a concurrent md start
        cycle(1, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0);
        cycle(1, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0);
        cycle(1, 0, 3, 0, 3, 0, 0, 1, 0, 1, 1);
        cycle(1, 8, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        // reset mid-div
        for (int i = 0; i < 2; i++) cycle(1, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0);
        async_reset();
        cycle(1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int mds, uh;
            mds = ($urandom_range(0, 7) == 0) ? 1 : 0;
            uh  = (mds == 1 || $urandom_range(0, 5) == 0) ? 1 : 0;
            cycle(($urandom_range(0, 7) != 0) ? 1 : 0,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  mds, $urandom_range(0, 1), uh,
                  ($urandom_range(0, 15) == 0) ? 1 : 0);
            if (n == 1500) async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
